rx_dllp_filter: RTL

Receive-side DLLP checker and queue that feeds the `dllp` / `dllp_valid` / `dllp_ready` input of the TX data link layer.

- Takes raw 48-bit DLLPs from the physical layer and verifies their CRC-16.
- Classifies each DLLP by type and drops corrupt or unsupported ones.
- Coalesces back-to-back ACKs and buffers the survivors in a small FIFO.
- The TX data link layer drains the FIFO through a valid/ready handshake to retire or replay retry-buffer entries.

---
 rtl/rx_dllp_filter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/rx_dllp_filter.sv
// rx_dllp_filter
//   Receive-side DLLP checker and queue. Verifies the CRC-16 of each 48-bit
//   DLLP from the physical layer, classifies it by type, drops corrupt or
//   unsupported DLLPs, coalesces back-to-back ACKs, and buffers survivors in a
//   small FIFO drained by the TX data link layer through valid/ready.
//
// Ports
//   clk            : rising-edge clock
//   reset_n        : synchronous active-low reset
//   phy_dllp       : [47:16] body, [15:0] received CRC
//   phy_dllp_valid : one DLLP per cycle, no backpressure
//   dllp           : head-of-queue DLLP body
//   dllp_valid     : queue non-empty
//   dllp_ready     : consumer accepts dllp this cycle
//   crc_err        : one-cycle pulse on CRC failure
//   crc_err_cnt    : saturating CRC failure count
//   drop_cnt       : saturating count of CRC-good DLLPs discarded
module rx_dllp_filter #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [47:0]      phy_dllp,
  input  logic             phy_dllp_valid,
  output logic [31:0]      dllp,
  output logic             dllp_valid,
  input  logic             dllp_ready,
  output logic             crc_err,
  output logic [CNT_W-1:0] crc_err_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int            AW      = $clog2(FIFO_DEPTH);
  localparam int            STAGES  = 2;
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  // Serial CRC-16, poly 0x100B, init 0xFFFF, MSB first, no reflection.
  function automatic logic [15:0] crc16(input logic [31:0] d);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 31; i >= 0; i--) begin
      if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h100B;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  // Input classification (registered into stage 1)
  logic [31:0] in_body;
  logic [7:0]  in_type;
  logic        in_ok, in_ack, in_nak, in_fc;

  assign in_body = phy_dllp[47:16];
  assign in_type = in_body[31:24];
  assign in_ok   = (~crc16(in_body)) == phy_dllp[15:0];
  assign in_ack  = in_type == 8'h00;
  assign in_nak  = in_type == 8'h10;
  assign in_fc   = in_type[7] | in_type[6];

  logic [STAGES:1] vld_pipe;
  logic [31:0]     s1_body, s2_body;
  logic            s1_ok, s1_ack, s1_sup;
  logic            s2_ack, s2_sup;

  // FIFO state
  logic [31:0]   mem     [FIFO_DEPTH];
  logic          mem_ack [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, tail;
  logic [AW:0]   count;
  logic          pop, full, coalesce, push, drop;

  assign dllp_valid = count != '0;
  assign dllp       = mem[rd_ptr];
  assign full       = count == DEPTH_C;
  assign pop        = dllp_valid & dllp_ready;
  assign tail       = wr_ptr - PTR_ONE;

  // A sole entry being popped cannot absorb the new ACK; it must be pushed.
  assign coalesce = vld_pipe[2] & s2_ack & dllp_valid & mem_ack[tail] &
                    ~((count == (AW+1)'(1)) & pop);
  assign push     = vld_pipe[2] & s2_sup & ~coalesce & (~full | pop);
  assign drop     = vld_pipe[2] & ~coalesce & ~push;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_pipe    <= '0;
      s1_body     <= '0;
      s1_ok       <= 1'b0;
      s1_ack      <= 1'b0;
      s1_sup      <= 1'b0;
      s2_body     <= '0;
      s2_ack      <= 1'b0;
      s2_sup      <= 1'b0;
      crc_err     <= 1'b0;
      crc_err_cnt <= '0;
      drop_cnt    <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i]     <= '0;
        mem_ack[i] <= 1'b0;
      end
    end else begin
      // stage 1: raw DLLP plus check/type flags
      vld_pipe[1] <= phy_dllp_valid;
      s1_body     <= in_body;
      s1_ok       <= in_ok;
      s1_ack      <= in_ack;
      s1_sup      <= in_ack | in_nak | in_fc;

      // stage 2: only CRC-good DLLPs advance
      vld_pipe[2] <= vld_pipe[1] & s1_ok;
      s2_body     <= s1_body;
      s2_ack      <= s1_ack;
      s2_sup      <= s1_sup;
      crc_err     <= vld_pipe[1] & ~s1_ok;
      if (vld_pipe[1] && !s1_ok && crc_err_cnt != '1)
        crc_err_cnt <= crc_err_cnt + CNT_W'(1);

      // push / coalesce / drop decision
      if (drop && drop_cnt != '1)
        drop_cnt <= drop_cnt + CNT_W'(1);
      if (coalesce)
        mem[tail] <= s2_body;
      if (push) begin
        mem[wr_ptr]     <= s2_body;
        mem_ack[wr_ptr] <= s2_ack;
        wr_ptr          <= wr_ptr + PTR_ONE;
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

endmodule
